// File: rtl/drive_sequencer.sv
// Motor drive sequencer: ramps PWM duty toward a commanded target, enforces a
// zero-duty dead time before direction reversals, and parks in HALT while the
// disable handler withholds Enable. A pause window halves the target (creep).
//
// Handshake: a command transfers on any rising clk edge where CmdValid and
// CmdReady are both 1. CmdReady depends only on the registered state (it is 0
// only in DEAD), so it never depends combinationally on CmdValid.
module drive_sequencer #(
  parameter int RAMP_DIV  = 1000,
  parameter int RAMP_STEP = 8,
  parameter int DEAD_TIME = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Enable,
  input  logic       Pause,
  input  logic       CmdValid,
  input  logic       CmdDir,
  input  logic [7:0] CmdDuty,
  output logic       CmdReady,
  output logic [7:0] Duty,
  output logic       Dir,
  output logic       MotorEn,
  output logic [2:0] State,
  output logic [7:0] HaltCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RAMP = 3'd1,
    S_RUN  = 3'd2,
    S_DEAD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam int TW = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
  localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);
  localparam logic [8:0]    STEP9     = 9'(RAMP_STEP);

  state_t          state;
  logic [7:0]      duty;
  logic            dir;
  logic            motor_en;
  logic [7:0]      tgt_duty;
  logic            tgt_dir;
  logic [7:0]      halt_count;
  logic            enable_q;
  logic [TW-1:0]   tick_cnt;
  logic [DW-1:0]   dead_cnt;

  logic            accept;
  logic            en_fall;
  logic            cmd_stop;
  logic            cmd_reverse;
  logic [7:0]      eff_duty;
  logic [8:0]      ramp_sum;
  logic [7:0]      ramp_duty;

  assign CmdReady    = (state != S_DEAD);
  assign accept      = CmdValid & CmdReady;
  assign en_fall     = enable_q & ~Enable;
  assign cmd_stop    = accept & (CmdDuty == 8'd0);
  assign cmd_reverse = accept & (CmdDuty != 8'd0) & (CmdDir != dir);

  // Creep during the pause window runs at half the latched target.
  assign eff_duty  = (Pause & Enable) ? {1'b0, tgt_duty[7:1]} : tgt_duty;

  // Ramp increment is done in 9 bits so a large step near 255 clamps to the
  // target instead of wrapping through zero.
  assign ramp_sum  = {1'b0, duty} + STEP9;
  assign ramp_duty = (ramp_sum > {1'b0, eff_duty}) ? eff_duty : ramp_sum[7:0];

  assign State     = state;
  assign Duty      = duty;
  assign Dir       = dir;
  assign MotorEn   = motor_en;
  assign HaltCount = halt_count;

  // Sequencer FSM, target latch and Enable-fall counter; Enable=0 overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      duty       <= 8'd0;
      dir        <= 1'b0;
      motor_en   <= 1'b0;
      tgt_duty   <= 8'd0;
      tgt_dir    <= 1'b0;
      halt_count <= 8'd0;
      enable_q   <= 1'b1;
      tick_cnt   <= '0;
      dead_cnt   <= '0;
    end else begin
      enable_q <= Enable;
      if (en_fall && (halt_count != 8'hFF)) begin
        halt_count <= halt_count + 8'd1;
      end

      // Every accepted command is latched, including while halted.
      if (accept) begin
        tgt_duty <= CmdDuty;
        tgt_dir  <= CmdDir;
      end

      if (!Enable) begin
        state    <= S_HALT;
        duty     <= 8'd0;
        motor_en <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            duty     <= 8'd0;
            motor_en <= 1'b0;
            if (cmd_reverse) begin
              state    <= S_DEAD;
              dead_cnt <= '0;
            end else if (accept && (CmdDuty != 8'd0)) begin
              state    <= S_RAMP;
              tick_cnt <= '0;
            end
          end

          S_RAMP: begin
            if (cmd_stop) begin
              state    <= S_IDLE;
              duty     <= 8'd0;
              motor_en <= 1'b0;
            end else if (cmd_reverse) begin
              state    <= S_DEAD;
              dead_cnt <= '0;
              duty     <= 8'd0;
              motor_en <= 1'b0;
            end else if (duty >= eff_duty) begin
              // Reached (or target dropped below) the effective target.
              state    <= S_RUN;
              duty     <= eff_duty;
              motor_en <= (eff_duty != 8'd0);
            end else if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              duty     <= ramp_duty;
              motor_en <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
              motor_en <= (duty != 8'd0);
            end
          end

          S_RUN: begin
            if (cmd_stop) begin
              state    <= S_IDLE;
              duty     <= 8'd0;
              motor_en <= 1'b0;
            end else if (cmd_reverse) begin
              state    <= S_DEAD;
              dead_cnt <= '0;
              duty     <= 8'd0;
              motor_en <= 1'b0;
            end else if (eff_duty > duty) begin
              state    <= S_RAMP;
              tick_cnt <= '0;
            end else if (eff_duty < duty) begin
              duty     <= eff_duty;
              motor_en <= (eff_duty != 8'd0);
            end
          end

          S_DEAD: begin
            duty     <= 8'd0;
            motor_en <= 1'b0;
            if (dead_cnt == DEAD_LAST) begin
              dir      <= tgt_dir;
              state    <= S_RAMP;
              tick_cnt <= '0;
            end else begin
              dead_cnt <= dead_cnt + DW'(1);
            end
          end

          S_HALT: begin
            duty     <= 8'd0;
            motor_en <= 1'b0;
            if (tgt_duty == 8'd0) begin
              state <= S_IDLE;
            end else if (tgt_dir != dir) begin
              state    <= S_DEAD;
              dead_cnt <= '0;
            end else begin
              state    <= S_RAMP;
              tick_cnt <= '0;
            end
          end

          default: begin
            state    <= S_IDLE;
            duty     <= 8'd0;
            motor_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/drive_sequencer.md
DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 Parameter RAMP_DIV, default 1000, clock cycles between ramp increments (>=1).
REQ-002 Parameter RAMP_STEP, default 8, duty increment per ramp tick (1..255).
REQ-003 Parameter DEAD_TIME, default 500, zero-duty cycles held before a direction reversal (>=1).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 Enable  in  1  drive permitted, from the disable handler; 0 = hard stop.
REQ-008 Pause  in  1  disable-handler pause window active; 1 with Enable=1 = creep period.
REQ-009 CmdValid  in  1  new motion command present this cycle.
REQ-010 CmdDir  in  1  commanded direction, 0 = forward, 1 = reverse.
REQ-011 CmdDuty  in  8  commanded duty; 0 = stop.
REQ-012 CmdReady  out  1  command accepted when CmdValid&CmdReady.
REQ-013 Duty  out  8  registered PWM duty to the motor driver.
REQ-014 Dir  out  1  registered direction to the motor driver.
REQ-015 MotorEn  out  1  registered driver enable; 1 only in RAMP or RUN with Duty>0.
REQ-016 State  out  3  IDLE=0, RAMP=1, RUN=2, DEAD=3, HALT=4.
REQ-017 HaltCount  out  8  count of Enable falling edges, saturating at 255.

Function
REQ-018 The block SHALL hold an internal target (TgtDuty 8b, TgtDir 1b), loaded on every accepted command.
REQ-019 CmdReady SHALL be 1 in every state except DEAD.
REQ-020 Effective target SHALL be TgtDuty>>1 while Pause=1 and Enable=1, else TgtDuty.
REQ-021 IDLE: Duty=0, MotorEn=0; an accepted command with CmdDuty>0 SHALL go to DEAD if CmdDir!=Dir, else to RAMP.
REQ-022 RAMP: a tick counter SHALL count RAMP_DIV cycles from entry (cleared on entry); on each tick Duty SHALL become min(Duty+RAMP_STEP, effective target), computed in 9 bits with no 8-bit wrap.
REQ-023 RAMP SHALL transition to RUN in the cycle after Duty equals the effective target.
REQ-024 RUN: Duty SHALL track the effective target; increases SHALL re-enter RAMP, and decreases SHALL apply on the next cycle with no ramp.
REQ-025 An accepted same-direction command in RAMP/RUN SHALL update the target only; the increase/decrease rules of REQ-024 apply.
REQ-026 An accepted opposite-direction command in RAMP/RUN SHALL force Duty=0 and MotorEn=0 next cycle and enter DEAD.
REQ-027 DEAD: Duty=0 for exactly DEAD_TIME cycles, then Dir<=TgtDir and enter RAMP from Duty=0.
REQ-028 An accepted command with CmdDuty=0 in any non-HALT state SHALL set Duty=0 next cycle and enter IDLE.
REQ-029 Enable=0 in any state SHALL, on the next edge, set Duty=0 and MotorEn=0 and enter HALT; this SHALL take priority over commands and DEAD timing.
REQ-030 HALT: commands SHALL still be accepted and latched; Dir SHALL be unchanged.
REQ-031 HALT exit on Enable=1: if TgtDuty=0, go to IDLE; if TgtDir!=Dir, go to DEAD; else go to RAMP from Duty=0.
REQ-032 HaltCount SHALL increment once per 1->0 transition of Enable (registered previous value, reset to 1) and saturate at 255.
REQ-033 If a command and Enable falling occur in the same cycle, the command SHALL be latched and the next state SHALL be HALT.

Reset
REQ-034 When rst=1, the block SHALL set State=IDLE, Duty=0, Dir=0, MotorEn=0, TgtDuty=0, TgtDir=0, HaltCount=0, and all counters to 0 on that edge, regardless of state.
REQ-035 CmdReady SHALL be 1 in the first cycle after reset.

Verification
REQ-036 The bench SHALL cover: RAMP_DIV=4, RAMP_STEP=8, cmd fwd duty 20 from IDLE -> Duty 8,16,20 at 4-cycle spacing, then RUN and MotorEn=1.
REQ-037 The bench SHALL cover: RUN fwd duty 200, cmd rev duty 100, DEAD_TIME=5 -> Duty=0 next cycle, 5 cycles in DEAD, then Dir=1 and ramp toward 100.
REQ-038 The bench SHALL cover: RUN duty 100, Enable=0 for 3 cycles, then Enable=1 with Pause=1 -> HALT with Duty=0, then ramp to 50; Pause=0 -> ramp to 100; HaltCount=1.
REQ-039 The bench SHALL cover: cmd duty 250 with RAMP_STEP=16 -> Duty steps 240 then 250, never 0 (no wrap).
REQ-040 The bench SHALL cover: CmdValid duty 60 in the same cycle as Enable falling -> HALT; on Enable rise with Pause=0, ramp to 60.
REQ-041 The bench SHALL cover: rst asserted mid-RAMP and 300 Enable pulses -> all outputs return to reset values; HaltCount saturates at 255.
